// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap controller.
// Selects the oldest pending exception, or an mret, or a level interrupt.
// It then updates the M-mode CSRs and issues a one-cycle PC redirect.
// It holds flush/busy until the pipeline acknowledges the drain.
// Optional feature: define TRAP_CTRL_VECTORED_EN to make mtvec[0] (MODE)
// writable, so that interrupts take the vectored target base+44.
module trap_ctrl #(
   parameter int              XLEN        = 64,
   parameter int              NUM_SRC     = 4,
   parameter logic [XLEN-1:0] MTVEC_RESET = {XLEN{1'b0}}
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_SRC-1:0]      exc_valid,
   input  logic [4*NUM_SRC-1:0]    exc_cause,
   input  logic [XLEN*NUM_SRC-1:0] exc_pc,
   input  logic [XLEN*NUM_SRC-1:0] exc_tval,
   input  logic                    irq,
   input  logic [XLEN-1:0]         irq_pc,
   input  logic                    mret_valid,
   input  logic                    csr_we,
   input  logic [11:0]             csr_addr,
   input  logic [XLEN-1:0]         csr_wdata,
   output logic [XLEN-1:0]         csr_rdata,
   input  logic                    drain_ack,
   output logic                    redirect_valid,
   output logic [XLEN-1:0]         redirect_pc,
   output logic                    flush,
   output logic                    busy
);

   localparam logic [11:0] ADDR_MSTATUS = 12'h300;
   localparam logic [11:0] ADDR_MTVEC   = 12'h305;
   localparam logic [11:0] ADDR_MEPC    = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
   localparam logic [11:0] ADDR_MTVAL   = 12'h343;
   localparam logic [11:0] ADDR_MCYCLE  = 12'hB00;

   // Word-alignment mask: clears bits [1:0].
   localparam logic [XLEN-1:0] ALIGN_MASK  = {{(XLEN-2){1'b1}}, 2'b00};
   localparam logic [XLEN-1:0] IRQ_VEC_OFF = {{(XLEN-6){1'b0}}, 6'd44};
   localparam logic [XLEN-1:0] IRQ_CAUSE   = {1'b1, {(XLEN-5){1'b0}}, 4'd11};
   localparam logic [XLEN-1:0] ONE         = {{(XLEN-1){1'b0}}, 1'b1};

`ifdef TRAP_CTRL_VECTORED_EN
   // MODE bit is writable; bit1 is always zero.
   localparam logic [XLEN-1:0] MTVEC_WMASK = {{(XLEN-2){1'b1}}, 2'b01};
`else
   // Direct mode only; MODE bit is hardwired zero.
   localparam logic [XLEN-1:0] MTVEC_WMASK = {{(XLEN-2){1'b1}}, 2'b00};
`endif

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_DRAIN = 1'b1
   } state_t;

   state_t          state_r;
   logic            mie_r;
   logic            mpie_r;
   logic [XLEN-1:0] mtvec_r;
   logic [XLEN-1:0] mepc_r;
   logic [XLEN-1:0] mcause_r;
   logic [XLEN-1:0] mtval_r;
   logic [XLEN-1:0] mcycle_r;

   logic [3:0]      sel_cause_s;
   logic [XLEN-1:0] sel_pc_s;
   logic [XLEN-1:0] sel_tval_s;
   logic            idle_s;
   logic            exc_any_s;
   logic            take_exc_s;
   logic            take_irq_s;
   logic            take_mret_s;
   logic            take_trap_s;
   logic            event_s;
   logic [XLEN-1:0] mtvec_base_s;
   logic [XLEN-1:0] irq_target_s;
   logic [XLEN-1:0] target_s;
   logic [XLEN-1:0] trap_epc_s;
   logic [XLEN-1:0] trap_cause_s;
   logic [XLEN-1:0] trap_tval_s;
   logic            wr_mstatus_s;
   logic            wr_mtvec_s;
   logic            wr_mepc_s;
   logic            wr_mcause_s;
   logic            wr_mtval_s;
   logic            wr_mcycle_s;

   // Oldest exception select: ascending scan, so the highest set index wins.
   always_comb begin
      sel_cause_s = 4'd0;
      sel_pc_s    = {XLEN{1'b0}};
      sel_tval_s  = {XLEN{1'b0}};
      for (int i = 0; i < NUM_SRC; i++) begin
         if (exc_valid[i]) begin
            sel_cause_s = exc_cause[4*i +: 4];
            sel_pc_s    = exc_pc[XLEN*i +: XLEN];
            sel_tval_s  = exc_tval[XLEN*i +: XLEN];
         end else begin
            sel_cause_s = sel_cause_s;
            sel_pc_s    = sel_pc_s;
            sel_tval_s  = sel_tval_s;
         end
      end
   end

   // Event priority in IDLE: exception, then mret, then enabled interrupt.
   always_comb begin
      idle_s      = (state_r == ST_IDLE);
      exc_any_s   = |exc_valid;
      take_exc_s  = idle_s & exc_any_s;
      take_mret_s = idle_s & ~exc_any_s & mret_valid;
      take_irq_s  = idle_s & ~exc_any_s & ~mret_valid & irq & mie_r;
      take_trap_s = take_exc_s | take_irq_s;
      event_s     = take_trap_s | take_mret_s;
   end

   // Redirect target and the CSR values written on trap entry.
   always_comb begin
      mtvec_base_s = mtvec_r & ALIGN_MASK;
`ifdef TRAP_CTRL_VECTORED_EN
      if (mtvec_r[0]) begin
         irq_target_s = mtvec_base_s + IRQ_VEC_OFF;
      end else begin
         irq_target_s = mtvec_base_s;
      end
`else
      irq_target_s = mtvec_base_s;
`endif
      if (take_exc_s) begin
         target_s     = mtvec_base_s;
         trap_epc_s   = sel_pc_s & ALIGN_MASK;
         trap_cause_s = {{(XLEN-4){1'b0}}, sel_cause_s};
         trap_tval_s  = sel_tval_s;
      end else if (take_irq_s) begin
         target_s     = irq_target_s;
         trap_epc_s   = irq_pc & ALIGN_MASK;
         trap_cause_s = IRQ_CAUSE;
         trap_tval_s  = {XLEN{1'b0}};
      end else begin
         target_s     = mepc_r;
         trap_epc_s   = irq_pc & ALIGN_MASK;
         trap_cause_s = IRQ_CAUSE;
         trap_tval_s  = {XLEN{1'b0}};
      end
   end

   // Software CSR write decode.
   always_comb begin
      wr_mstatus_s = csr_we & (csr_addr == ADDR_MSTATUS);
      wr_mtvec_s   = csr_we & (csr_addr == ADDR_MTVEC);
      wr_mepc_s    = csr_we & (csr_addr == ADDR_MEPC);
      wr_mcause_s  = csr_we & (csr_addr == ADDR_MCAUSE);
      wr_mtval_s   = csr_we & (csr_addr == ADDR_MTVAL);
      wr_mcycle_s  = csr_we & (csr_addr == ADDR_MCYCLE);
   end

   // CSR state: hardware trap/mret updates take precedence over software writes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mie_r    <= 1'b0;
         mpie_r   <= 1'b0;
         mtvec_r  <= MTVEC_RESET & MTVEC_WMASK;
         mepc_r   <= {XLEN{1'b0}};
         mcause_r <= {XLEN{1'b0}};
         mtval_r  <= {XLEN{1'b0}};
         mcycle_r <= {XLEN{1'b0}};
      end else begin
         if (wr_mcycle_s) begin
            mcycle_r <= csr_wdata;
         end else begin
            mcycle_r <= mcycle_r + ONE;
         end

         if (wr_mtvec_s) begin
            mtvec_r <= csr_wdata & MTVEC_WMASK;
         end

         if (take_trap_s) begin
            mepc_r   <= trap_epc_s;
            mcause_r <= trap_cause_s;
            mtval_r  <= trap_tval_s;
         end else begin
            if (wr_mepc_s) begin
               mepc_r <= csr_wdata & ALIGN_MASK;
            end
            if (wr_mcause_s) begin
               mcause_r <= csr_wdata;
            end
            if (wr_mtval_s) begin
               mtval_r <= csr_wdata;
            end
         end

         if (take_trap_s) begin
            mpie_r <= mie_r;
            mie_r  <= 1'b0;
         end else if (take_mret_s) begin
            mie_r  <= mpie_r;
            mpie_r <= 1'b1;
         end else if (wr_mstatus_s) begin
            mie_r  <= csr_wdata[3];
            mpie_r <= csr_wdata[7];
         end
      end
   end

   // Control FSM with registered redirect/flush/busy outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r        <= ST_IDLE;
         redirect_valid <= 1'b0;
         redirect_pc    <= {XLEN{1'b0}};
         flush          <= 1'b0;
         busy           <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (event_s) begin
                  state_r        <= ST_DRAIN;
                  redirect_valid <= 1'b1;
                  redirect_pc    <= target_s;
                  flush          <= 1'b1;
                  busy           <= 1'b1;
               end else begin
                  redirect_valid <= 1'b0;
               end
            end
            ST_DRAIN: begin
               redirect_valid <= 1'b0;
               if (drain_ack) begin
                  state_r <= ST_IDLE;
                  flush   <= 1'b0;
                  busy    <= 1'b0;
               end
            end
            default: begin
               state_r        <= ST_IDLE;
               redirect_valid <= 1'b0;
               flush          <= 1'b0;
               busy           <= 1'b0;
            end
         endcase
      end
   end

   // Combinational CSR read; unimplemented addresses read zero.
   always_comb begin
      csr_rdata = {XLEN{1'b0}};
      case (csr_addr)
         ADDR_MSTATUS: csr_rdata = {{(XLEN-8){1'b0}}, mpie_r, 3'b000, mie_r, 3'b000};
         ADDR_MTVEC:   csr_rdata = mtvec_r;
         ADDR_MEPC:    csr_rdata = mepc_r;
         ADDR_MCAUSE:  csr_rdata = mcause_r;
         ADDR_MTVAL:   csr_rdata = mtval_r;
         ADDR_MCYCLE:  csr_rdata = mcycle_r;
         default:      csr_rdata = {XLEN{1'b0}};
      endcase
   end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed self-checking bench for trap_ctrl (XLEN=64, NUM_SRC=4).
// Expected values are hand-computed; the interrupt target depends on
// whether TRAP_CTRL_VECTORED_EN is defined for the build.
module tb_trap_ctrl;

   localparam int XLEN    = 64;
   localparam int NUM_SRC = 4;
   localparam logic [63:0] RST_VEC = 64'h0000_0000_0000_0080;

   logic                    clk;
   logic                    rst;
   logic [NUM_SRC-1:0]      exc_valid;
   logic [4*NUM_SRC-1:0]    exc_cause;
   logic [XLEN*NUM_SRC-1:0] exc_pc;
   logic [XLEN*NUM_SRC-1:0] exc_tval;
   logic                    irq;
   logic [XLEN-1:0]         irq_pc;
   logic                    mret_valid;
   logic                    csr_we;
   logic [11:0]             csr_addr;
   logic [XLEN-1:0]         csr_wdata;
   logic [XLEN-1:0]         csr_rdata;
   logic                    drain_ack;
   logic                    redirect_valid;
   logic [XLEN-1:0]         redirect_pc;
   logic                    flush;
   logic                    busy;

   int n_checks = 0;
   int n_fails  = 0;

   logic [63:0] exp_mtvec_v;
   logic [63:0] exp_irq_pc_v;

   trap_ctrl #(
      .XLEN        (XLEN),
      .NUM_SRC     (NUM_SRC),
      .MTVEC_RESET (RST_VEC)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .exc_valid      (exc_valid),
      .exc_cause      (exc_cause),
      .exc_pc         (exc_pc),
      .exc_tval       (exc_tval),
      .irq            (irq),
      .irq_pc         (irq_pc),
      .mret_valid     (mret_valid),
      .csr_we         (csr_we),
      .csr_addr       (csr_addr),
      .csr_wdata      (csr_wdata),
      .csr_rdata      (csr_rdata),
      .drain_ack      (drain_ack),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .flush          (flush),
      .busy           (busy)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input string tag, input logic [11:0] addr, input logic [63:0] exp);
      csr_addr = addr;
      #1;
      check(tag, csr_rdata, exp);
   endtask

   task automatic wr(input logic [11:0] addr, input logic [63:0] data);
      csr_we    = 1'b1;
      csr_addr  = addr;
      csr_wdata = data;
      tick();
      csr_we    = 1'b0;
   endtask

   task automatic set_src(input int idx, input logic [3:0] c, input logic [63:0] pc, input logic [63:0] tv);
      exc_cause[4*idx +: 4]   = c;
      exc_pc[XLEN*idx +: XLEN]   = pc;
      exc_tval[XLEN*idx +: XLEN] = tv;
   endtask

   task automatic check_outs(input string tag, input logic rv, input logic [63:0] pc, input logic fl, input logic bs);
      check({tag, "_rv"}, {63'd0, redirect_valid}, {63'd0, rv});
      check({tag, "_pc"}, redirect_pc, pc);
      check({tag, "_flush"}, {63'd0, flush}, {63'd0, fl});
      check({tag, "_busy"}, {63'd0, busy}, {63'd0, bs});
   endtask

   initial begin
`ifdef TRAP_CTRL_VECTORED_EN
      exp_mtvec_v  = 64'h201;
      exp_irq_pc_v = 64'h22C;
`else
      exp_mtvec_v  = 64'h200;
      exp_irq_pc_v = 64'h200;
`endif
      rst        = 1'b1;
      exc_valid  = 4'b0000;
      exc_cause  = 16'h0000;
      exc_pc     = {(XLEN*NUM_SRC){1'b0}};
      exc_tval   = {(XLEN*NUM_SRC){1'b0}};
      irq        = 1'b0;
      irq_pc     = 64'h0;
      mret_valid = 1'b0;
      csr_we     = 1'b0;
      csr_addr   = 12'h000;
      csr_wdata  = 64'h0;
      drain_ack  = 1'b0;

      // 1. reset state
      #3;
      check_outs("reset", 1'b0, 64'h0, 1'b0, 1'b0);
      rd("rst_mstatus", 12'h300, 64'h0);
      rd("rst_mtvec",   12'h305, RST_VEC);
      rd("rst_mepc",    12'h341, 64'h0);
      rd("rst_mcause",  12'h342, 64'h0);
      rd("rst_mtval",   12'h343, 64'h0);
      rd("rst_mcycle",  12'hB00, 64'h0);
      rd("rst_unimpl",  12'h344, 64'h0);
      tick();
      rst = 1'b0;

      // mstatus implements only MIE/MPIE
      wr(12'h300, 64'hFFFF_FFFF_FFFF_FFF7);
      rd("mstatus_mask", 12'h300, 64'h80);
      wr(12'h344, 64'h1234);
      rd("unimpl_write", 12'h344, 64'h0);
      wr(12'h300, 64'h8);
      rd("mstatus_mie", 12'h300, 64'h08);

      // 2. exception: sources 3 and 1 pending, 3 is oldest
      wr(12'h305, 64'h100);
      rd("mtvec_wr", 12'h305, 64'h100);
      set_src(3, 4'd5, 64'h2004, 64'hDEAD);
      set_src(1, 4'd2, 64'h1000, 64'h11);
      exc_valid = 4'b1010;
      tick();
      exc_valid = 4'b0000;
      check_outs("exc_t1", 1'b1, 64'h100, 1'b1, 1'b1);
      rd("exc_mepc",    12'h341, 64'h2004);
      rd("exc_mcause",  12'h342, 64'h5);
      rd("exc_mtval",   12'h343, 64'hDEAD);
      rd("exc_mstatus", 12'h300, 64'h80);
      tick();
      check_outs("exc_t2", 1'b0, 64'h100, 1'b1, 1'b1);
      drain_ack = 1'b1;
      tick();
      drain_ack = 1'b0;
      check_outs("exc_done", 1'b0, 64'h100, 1'b0, 1'b0);

      // 4. mret returns to mepc, MIE=MPIE, MPIE=1
      mret_valid = 1'b1;
      tick();
      mret_valid = 1'b0;
      check_outs("mret_t1", 1'b1, 64'h2004, 1'b1, 1'b1);
      rd("mret_mstatus", 12'h300, 64'h88);
      rd("mret_mcause",  12'h342, 64'h5);
      drain_ack = 1'b1;
      tick();
      drain_ack = 1'b0;
      check_outs("mret_done", 1'b0, 64'h2004, 1'b0, 1'b0);

      // 4b. exception at index 0 beats mret in the same cycle
      set_src(0, 4'd2, 64'h4002, 64'h55);
      exc_valid  = 4'b0001;
      mret_valid = 1'b1;
      tick();
      exc_valid  = 4'b0000;
      mret_valid = 1'b0;
      check_outs("exc_vs_mret", 1'b1, 64'h100, 1'b1, 1'b1);
      rd("exm_mepc",    12'h341, 64'h4000);
      rd("exm_mcause",  12'h342, 64'h2);
      rd("exm_mtval",   12'h343, 64'h55);
      rd("exm_mstatus", 12'h300, 64'h80);

      // 5. events during DRAIN are ignored
      set_src(2, 4'd7, 64'h5000, 64'h77);
      exc_valid = 4'b0100;
      irq       = 1'b1;
      irq_pc    = 64'h7000;
      for (int k = 0; k < 3; k++) begin
         tick();
         check_outs("drain_ign", 1'b0, 64'h100, 1'b1, 1'b1);
      end
      exc_valid = 4'b0000;
      irq       = 1'b0;
      rd("drain_mepc",   12'h341, 64'h4000);
      rd("drain_mcause", 12'h342, 64'h2);
      rd("drain_mtval",  12'h343, 64'h55);
      drain_ack = 1'b1;
      tick();
      drain_ack = 1'b0;
      check_outs("drain_done", 1'b0, 64'h100, 1'b0, 1'b0);

      // interrupt with MIE=0 is not taken
      irq    = 1'b1;
      irq_pc = 64'h3003;
      tick();
      irq = 1'b0;
      check_outs("irq_masked", 1'b0, 64'h100, 1'b0, 1'b0);

      // 3. interrupt entry, direct or vectored target
      wr(12'h305, 64'h201);
      rd("mtvec_mode", 12'h305, exp_mtvec_v);
      wr(12'h300, 64'h8);
      irq = 1'b1;
      tick();
      irq = 1'b0;
      check_outs("irq_t1", 1'b1, exp_irq_pc_v, 1'b1, 1'b1);
      rd("irq_mcause",  12'h342, 64'h8000_0000_0000_000B);
      rd("irq_mepc",    12'h341, 64'h3000);
      rd("irq_mtval",   12'h343, 64'h0);
      rd("irq_mstatus", 12'h300, 64'h80);
      drain_ack = 1'b1;
      tick();
      drain_ack = 1'b0;
      check_outs("irq_done", 1'b0, exp_irq_pc_v, 1'b0, 1'b0);

      // 6. mcycle load and wrap
      wr(12'hB00, 64'hFFFF_FFFF_FFFF_FFFE);
      rd("mcycle_load", 12'hB00, 64'hFFFF_FFFF_FFFF_FFFE);
      tick();
      rd("mcycle_max", 12'hB00, 64'hFFFF_FFFF_FFFF_FFFF);
      tick();
      rd("mcycle_wrap", 12'hB00, 64'h0);

      // trap update wins over a same-cycle write to mepc
      set_src(2, 4'd4, 64'h6000, 64'h66);
      exc_valid = 4'b0100;
      csr_we    = 1'b1;
      csr_addr  = 12'h341;
      csr_wdata = 64'h9998;
      tick();
      csr_we    = 1'b0;
      exc_valid = 4'b0000;
      check_outs("conflict", 1'b1, 64'h200, 1'b1, 1'b1);
      rd("conf_mepc",   12'h341, 64'h6000);
      rd("conf_mcause", 12'h342, 64'h4);
      rd("conf_mtval",  12'h343, 64'h66);

      // reset asserted mid-DRAIN clears everything at once
      rst = 1'b1;
      #1;
      check_outs("rst_mid", 1'b0, 64'h0, 1'b0, 1'b0);
      rd("rst_mid_mtvec", 12'h305, RST_VEC);
      rd("rst_mid_mepc",  12'h341, 64'h0);
      tick();
      rst = 1'b0;
      tick();
      check_outs("post_rst", 1'b0, 64'h0, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
